// File: rtl/crypt_pkg.sv
// Shared widths and stage records for the crypt result matcher.
package crypt_pkg;

  localparam int HALF_W     = 32;
  localparam int TGT_W      = 2 * HALF_W;
  localparam int ID_W       = 32;
  localparam int CHECKED_W  = 48;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  // Candidate as captured from the last round stage.
  typedef struct packed {
    logic              valid;
    logic [HALF_W-1:0] l;
    logic [HALF_W-1:0] r;
    logic [ID_W-1:0]   id;
  } s1_t;

  // Candidate after comparison against the target halves.
  typedef struct packed {
    logic            valid;
    logic            eq_hi;
    logic            eq_lo;
    logic [ID_W-1:0] id;
  } s2_t;

  // A candidate is a hit only when it is valid and both halves agree.
  function automatic logic is_hit(input s2_t s);
    return s.valid & s.eq_hi & s.eq_lo;
  endfunction

endpackage

// File: rtl/match_fifo.sv
// Depth-4 first-word-fall-through FIFO holding IDs of matching candidates.
// Handshake: dout is meaningful whenever empty is low; a pop is accepted only
// while empty is low, and push is never back-pressured -- a push that cannot
// be stored (full, no pop in the same cycle) is dropped and flagged.
module match_fifo
  import crypt_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            push,
  input  logic [ID_W-1:0] din,
  input  logic            pop,
  output logic [ID_W-1:0] dout,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  logic [ID_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  // A pop on empty is ignored; a full FIFO still accepts a push if the head
  // leaves in the same cycle.
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign dout     = empty ? '0 : mem[rd_ptr];
  assign overflow = overflow_q;

  // Storage write; contents need no reset since empty masks dout.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        overflow_q <= 1'b0;
    else if (push & full & ~pop_ok) overflow_q <= 1'b1;
  end

endmodule

// File: rtl/crypt_result_match.sv
// Compares finished crypt candidates against a 64-bit target and queues the
// IDs of matches. Pipeline: S1 capture, S2 compare, S3 hit decision, then a
// write-port register so a match becomes visible on the fourth edge after
// its capture edge.
module crypt_result_match
  import crypt_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [HALF_W-1:0]    L_in,
  input  logic [HALF_W-1:0]    R_in,
  input  logic                 VALID_in,
  input  logic [ID_W-1:0]      ID_in,
  input  logic                 TGT_WE,
  input  logic [TGT_W-1:0]     TGT_DATA,
  input  logic                 RD_EN,
  output logic [ID_W-1:0]      MATCH_ID,
  output logic                 MATCH_EMPTY,
  output logic                 OVERFLOW,
  output logic [CHECKED_W-1:0] CHECKED
);

  logic [TGT_W-1:0]     tgt_q;
  s1_t                  s1_q;
  s2_t                  s2_q;
  logic                 s3_push;
  logic [ID_W-1:0]      s3_id;
  logic                 wr_push;
  logic [ID_W-1:0]      wr_id;
  logic [CHECKED_W-1:0] checked_q;
  logic                 fifo_full;

  // Target register; a candidate uses whatever value is here when it
  // leaves S1, so a write in the cycle after a beat does not affect it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         tgt_q <= '0;
    else if (TGT_WE) tgt_q <= TGT_DATA;
  end

  // S1: capture the candidate every cycle, no back-pressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) s1_q <= '0;
    else     s1_q <= '{valid: VALID_in, l: L_in, r: R_in, id: ID_in};
  end

  // S2: register the per-half equality results (L against 63:32, R against 31:0).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) s2_q <= '0;
    else     s2_q <= '{valid: s1_q.valid,
                       eq_hi: (s1_q.l == tgt_q[TGT_W-1:HALF_W]),
                       eq_lo: (s1_q.r == tgt_q[HALF_W-1:0]),
                       id:    s1_q.id};
  end

  // S3: decide the hit, then hold it one more stage as the FIFO write port.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s3_push <= 1'b0;
      s3_id   <= '0;
      wr_push <= 1'b0;
      wr_id   <= '0;
    end else begin
      s3_push <= is_hit(s2_q);
      s3_id   <= s2_q.id;
      wr_push <= s3_push;
      wr_id   <= s3_id;
    end
  end

  // Candidate counter, counted at capture and wrapping at its width.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           checked_q <= '0;
    else if (VALID_in) checked_q <= checked_q + CHECKED_W'(1);
  end

  assign CHECKED = checked_q;

  match_fifo u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (wr_push),
    .din      (wr_id),
    .pop      (RD_EN),
    .dout     (MATCH_ID),
    .empty    (MATCH_EMPTY),
    .full     (fifo_full),
    .overflow (OVERFLOW)
  );

  // A full FIFO can never report empty.
  full_not_empty_a: assert property (@(posedge CLK) disable iff (RST)
    fifo_full |-> !MATCH_EMPTY);

endmodule

// File: tb/tb_crypt_result_match.sv
// Bench for crypt_result_match: directed scenarios plus a random phase,
// checked against a scoreboard queue of expected FIFO contents.
module tb_crypt_result_match;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] l_in = '0;
  logic [31:0] r_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] id_in = '0;
  logic        tgt_we = 1'b0;
  logic [63:0] tgt_data = '0;
  logic        rd_en = 1'b0;
  logic [31:0] match_id;
  logic        match_empty;
  logic        overflow;
  logic [47:0] checked;

  crypt_result_match dut (
    .CLK         (clk),
    .RST         (rst),
    .L_in        (l_in),
    .R_in        (r_in),
    .VALID_in    (valid_in),
    .ID_in       (id_in),
    .TGT_WE      (tgt_we),
    .TGT_DATA    (tgt_data),
    .RD_EN       (rd_en),
    .MATCH_ID    (match_id),
    .MATCH_EMPTY (match_empty),
    .OVERFLOW    (overflow),
    .CHECKED     (checked)
  );

  // Clock
  always #5 clk = ~clk;

  // Model state
  logic [31:0] exp_q[$];
  logic [63:0] m_tgt;
  logic        m_ovf;
  logic [47:0] m_checked;
  logic        p_hit [4];
  logic [31:0] p_id  [4];
  int          n_checks = 0;
  int          n_errors = 0;

  localparam logic [63:0] TGT_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] TGT_B = 64'hFEDCBA9876543210;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    check("empty",    64'(match_empty), 64'(exp_q.size() == 0));
    check("match_id", 64'(match_id),    (exp_q.size() == 0) ? 64'd0 : 64'(exp_q[0]));
    check("overflow", 64'(overflow),    64'(m_ovf));
    check("checked",  64'(checked),     64'(m_checked));
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_tgt     = '0;
    m_ovf     = 1'b0;
    m_checked = '0;
    for (int k = 0; k < 4; k++) begin
      p_hit[k] = 1'b0;
      p_id[k]  = '0;
    end
  endtask

  // Asynchronous reset held across one clock edge; called #1 after an edge
  // (or before the first edge) and releases #1 after the next edge.
  task automatic do_reset();
    valid_in = 1'b0; tgt_we = 1'b0; rd_en = 1'b0;
    l_in = '0; r_in = '0; id_in = '0; tgt_data = '0;
    rst = 1'b1;
    clear_model();
    #1;
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;
  endtask

  // One clock cycle: drive, advance the model across the edge, compare.
  task automatic cycle(input logic v, input logic [31:0] l, input logic [31:0] r,
                       input logic [31:0] id, input logic we, input logic [63:0] tgt,
                       input logic rd);
    logic        hit;
    logic        pop_ok;
    logic        c_hit;
    logic [31:0] c_id;
    valid_in = v; l_in = l; r_in = r; id_in = id;
    tgt_we = we; tgt_data = tgt; rd_en = rd;
    // A target written in the same cycle as a beat is seen by that beat.
    if (we) m_tgt = tgt;
    hit    = v && (l == m_tgt[63:32]) && (r == m_tgt[31:0]);
    pop_ok = rd && (exp_q.size() > 0);
    if (pop_ok) check("rd_head", 64'(match_id), 64'(exp_q[0]));
    c_hit = p_hit[3];
    c_id  = p_id[3];
    @(posedge clk); #1;
    for (int k = 3; k > 0; k--) begin
      p_hit[k] = p_hit[k-1];
      p_id[k]  = p_id[k-1];
    end
    p_hit[0] = hit;
    p_id[0]  = id;
    if (pop_ok) void'(exp_q.pop_front());
    if (c_hit) begin
      if (exp_q.size() < 4) exp_q.push_back(c_id);
      else                  m_ovf = 1'b1;
    end
    if (v) m_checked = m_checked + 48'd1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] l, input logic [31:0] r, input logic [31:0] id);
    cycle(1'b1, l, r, id, 1'b0, '0, 1'b0);
  endtask

  task automatic read_one();
    cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic set_tgt(input logic [63:0] t);
    cycle(1'b0, '0, '0, '0, 1'b1, t, 1'b0);
  endtask

  initial begin
    clear_model();
    #2;
    do_reset();

    // Single match: visible exactly on the fourth edge after capture.
    set_tgt(TGT_A);
    beat(32'h01234567, 32'h89ABCDEF, 32'd7);
    idle(3);
    check("lat_edge3_empty", 64'(match_empty), 64'd1);
    idle(1);
    check("lat_edge4_empty", 64'(match_empty), 64'd0);
    check("lat_id",          64'(match_id),    64'd7);
    check("lat_checked",     64'(checked),     64'd1);
    read_one();
    read_one();  // pop on empty is ignored

    // 100 beats, L matches, R never matches.
    do_reset();
    set_tgt(TGT_A);
    for (int i = 0; i < 100; i++)
      beat(32'h01234567, 32'h89ABCDEF ^ 32'($urandom_range(1, 65535)), 32'(i));
    idle(6);
    check("r_diff_empty",   64'(match_empty), 64'd1);
    check("r_diff_checked", 64'(checked),     64'd100);

    // Six matches, no reads: 5 and 6 dropped, overflow sticky.
    do_reset();
    set_tgt(TGT_A);
    for (int i = 1; i <= 6; i++) beat(32'h01234567, 32'h89ABCDEF, 32'(i));
    idle(5);
    check("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) read_one();
    check("ovf_drain_empty", 64'(match_empty), 64'd1);
    read_one();
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO with a pop in the same cycle as a new push of ID 9.
    do_reset();
    set_tgt(TGT_A);
    for (int i = 1; i <= 4; i++) beat(32'h01234567, 32'h89ABCDEF, 32'(i));
    idle(5);
    beat(32'h01234567, 32'h89ABCDEF, 32'd9);
    idle(3);
    read_one();  // lands on the push-commit cycle
    check("fullpop_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) read_one();
    check("fullpop_last_id",    64'(match_id),    64'd9);
    check("fullpop_last_empty", 64'(match_empty), 64'd0);
    read_one();
    check("fullpop_drained", 64'(match_empty), 64'd1);

    // Reset while a match is in flight: nothing emerges afterwards.
    do_reset();
    set_tgt(TGT_A);
    beat(32'h01234567, 32'h89ABCDEF, 32'd5);
    do_reset();
    idle(8);
    check("rst_flight_empty",   64'(match_empty), 64'd1);
    check("rst_flight_checked", 64'(checked),     64'd0);

    // Target changed the cycle after a beat matching the old target.
    do_reset();
    set_tgt(TGT_A);
    beat(32'h01234567, 32'h89ABCDEF, 32'd21);
    set_tgt(TGT_B);
    beat(32'h01234567, 32'h89ABCDEF, 32'd22);  // old target now, no match
    beat(32'hFEDCBA98, 32'h76543210, 32'd23);  // new target, match
    idle(6);
    check("tgt_old_match", 64'(match_id), 64'd21);
    read_one();
    check("tgt_new_match", 64'(match_id), 64'd23);
    read_one();

    // Random traffic: mixed hits, half hits, reads and target changes.
    do_reset();
    set_tgt(64'({$urandom, $urandom}));
    for (int i = 0; i < 600; i++) begin
      logic        v;
      logic        we;
      logic        rd;
      logic [31:0] l;
      logic [31:0] r;
      logic [63:0] t;
      int          sel;
      v   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      l   = (sel == 0 || sel == 1) ? m_tgt[63:32] : $urandom;
      r   = (sel == 0 || sel == 2) ? m_tgt[31:0]  : $urandom;
      we  = ($urandom_range(0, 39) == 0);
      t   = {$urandom, $urandom};
      rd  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      cycle(v, l, r, 32'($urandom), we, t, rd);
    end
    idle(5);
    while (exp_q.size() > 0) read_one();
    check("rand_drained", 64'(match_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
